// File: rtl/ups_da_mc.sv
// ups_da_mc: multi-channel SPI DAC master.
// NCH DACs share sclk / cs_n / ldac_n and each has its own dout line.
// Writes land in per-channel shadow registers and set a pending flag.
// Any pending flag starts one frame that carries the shadow value of every channel.
// Frame sequence: SETUP, FW SCLK bits MSB first, HOLD, optional LDAC, GAP.
// Optional feature: define UPS_DA_MC_LDAC_EN to add the LDAC state, which drives
// a 2*DIV-cycle ldac_n pulse after each frame. Without it, ldac_n stays low
// (except in reset) and the DACs update when cs_n rises.
module ups_da_mc #(
  parameter int NCH = 2,
  parameter int DW  = 12,
  parameter int FW  = 16,
  parameter int DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    dv,
  input  logic [NCH*DW-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic [NCH-1:0]    dout,
  output logic              cs_n,
  output logic              ldac_n
);

  // state | meaning
  // IDLE  | waiting for a pending channel; sclk=1, cs_n=1
  // SETUP | one half-period with cs_n low before the first falling sclk
  // SHIFT | FW bits, each DIV cycles low then DIV cycles high
  // HOLD  | one half-period with sclk high after the last bit; cs_n rises on exit
  // LDAC  | two half-periods with ldac_n low (only with UPS_DA_MC_LDAC_EN)
  // GAP   | one half-period of cs_n high; done pulses on the return to IDLE
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_LDAC,
    S_GAP
  } state_t;

  localparam int CW = $clog2(2 * DIV);
  localparam int BW = (FW > 1) ? $clog2(FW) : 1;
  localparam logic [CW-1:0] HALF_LD  = CW'(DIV - 1);
  localparam logic [CW-1:0] LDAC_LD  = CW'(2 * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DW-1:0]   shadow     [NCH];
  logic [FW-1:0]   shadow_ext [NCH];
  logic [FW-1:0]   shreg      [NCH];
  logic [NCH-1:0]  pending;
  logic            snap;
  logic            hp_tc;

  // The snapshot edge: IDLE with at least one registered pending flag.
  assign snap  = (state == S_IDLE) && (|pending);
  // The half-period down-counter has reached terminal count.
  assign hp_tc = (cnt == '0);

  // Right-justify each shadow in a frame; the upper FW-DW bits are zero.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      shadow_ext[c] = FW'(shadow[c]);
    end
  end

  // Shadow registers accept writes in any state. A write on the snapshot edge keeps its pending flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        shadow[c] <= '0;
      end
      pending <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (dv[c]) begin
          shadow[c] <= data[c*DW +: DW];
        end
      end
      if (snap) begin
        pending <= dv;
      end else begin
        pending <= pending | dv;
      end
    end
  end

  // Frame sequencer: all SPI outputs are registered and paced by the half-period counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b1;
      cs_n    <= 1'b1;
      ldac_n  <= 1'b1;
      dout    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        shreg[c] <= '0;
      end
    end else begin
      done <= 1'b0;
`ifndef UPS_DA_MC_LDAC_EN
      ldac_n <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (snap) begin
            for (int c = 0; c < NCH; c++) begin
              shreg[c] <= shadow_ext[c];
              dout[c]  <= shadow_ext[c][FW-1];
            end
            cs_n  <= 1'b0;
            sclk  <= 1'b1;
            busy  <= 1'b1;
            cnt   <= HALF_LD;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (hp_tc) begin
            sclk    <= 1'b0;
            cnt     <= HALF_LD;
            bit_cnt <= LAST_BIT;
            state   <= S_SHIFT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_SHIFT: begin
          if (!hp_tc) begin
            cnt <= cnt - CW'(1);
          end else if (!sclk) begin
            sclk <= 1'b1;
            cnt  <= HALF_LD;
          end else if (bit_cnt == '0) begin
            cnt   <= HALF_LD;
            state <= S_HOLD;
          end else begin
            // Falling sclk: present the next bit to the DACs.
            sclk    <= 1'b0;
            cnt     <= HALF_LD;
            bit_cnt <= bit_cnt - BW'(1);
            for (int c = 0; c < NCH; c++) begin
              dout[c]  <= shreg[c][FW-2];
              shreg[c] <= shreg[c] << 1;
            end
          end
        end
        S_HOLD: begin
          if (hp_tc) begin
            cs_n <= 1'b1;
`ifdef UPS_DA_MC_LDAC_EN
            ldac_n <= 1'b0;
            cnt    <= LDAC_LD;
            state  <= S_LDAC;
`else
            cnt   <= HALF_LD;
            state <= S_GAP;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`ifdef UPS_DA_MC_LDAC_EN
        S_LDAC: begin
          if (hp_tc) begin
            ldac_n <= 1'b1;
            cnt    <= HALF_LD;
            state  <= S_GAP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif
        S_GAP: begin
          if (hp_tc) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ups_da_mc.sv
// tb_ups_da_mc: directed bench for ups_da_mc.
// Instance dut_a uses the default parameters. Instance dut_b uses NCH=4 and DIV=2.
// Expected frame timing depends on whether UPS_DA_MC_LDAC_EN is defined.
module tb_ups_da_mc;

`ifdef UPS_DA_MC_LDAC_EN
  localparam int   EXP_BUSY_A = 148;
  localparam int   EXP_LDAC_A = 8;
  localparam int   EXP_BUSY_B = 74;
  localparam int   EXP_LDAC_B = 4;
  localparam logic EXP_LDAC_IDLE = 1'b1;
`else
  localparam int   EXP_BUSY_A = 140;
  localparam int   EXP_LDAC_A = 141;
  localparam int   EXP_BUSY_B = 70;
  localparam int   EXP_LDAC_B = 71;
  localparam logic EXP_LDAC_IDLE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  dv_a;
  logic [23:0] data_a;
  logic        busy_a, done_a, sclk_a, cs_n_a, ldac_n_a;
  logic [1:0]  dout_a;
  logic [3:0]  dv_b;
  logic [47:0] data_b;
  logic        busy_b, done_b, sclk_b, cs_n_b, ldac_n_b;
  logic [3:0]  dout_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ups_da_mc dut_a (
    .clk(clk), .rst_n(rst_n), .dv(dv_a), .data(data_a), .busy(busy_a), .done(done_a),
    .sclk(sclk_a), .dout(dout_a), .cs_n(cs_n_a), .ldac_n(ldac_n_a)
  );

  ups_da_mc #(.NCH(4), .DW(12), .FW(16), .DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .dv(dv_b), .data(data_b), .busy(busy_b), .done(done_b),
    .sclk(sclk_b), .dout(dout_b), .cs_n(cs_n_b), .ldac_n(ldac_n_b)
  );

  // Record one frame from its first cycle up to and including the done cycle.
  // Bits are taken on each rising sclk edge while cs_n is low.
  task automatic capture(input bit sel, output int cs_low, output int busy_hi,
                         output int ldac_low, output int rises,
                         output logic [3:0][15:0] bits, output logic first_cs,
                         output bit timed_out);
    logic ps, cs, sc, ld, dn, bz;
    logic [3:0] d;
    cs_low = 0; busy_hi = 0; ldac_low = 0; rises = 0; bits = '0;
    first_cs = 1'bx; timed_out = 1'b1; ps = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sel) begin
        cs = cs_n_b; sc = sclk_b; ld = ldac_n_b; dn = done_b; bz = busy_b; d = dout_b;
      end else begin
        cs = cs_n_a; sc = sclk_a; ld = ldac_n_a; dn = done_a; bz = busy_a; d = {2'b00, dout_a};
      end
      if (i == 0) first_cs = cs;
      if (!cs) cs_low++;
      if (bz) busy_hi++;
      if (!ld) ldac_low++;
      if (!ps && sc && !cs) begin
        rises++;
        for (int ch = 0; ch < 4; ch++) bits[ch] = {bits[ch][14:0], d[ch]};
      end
      ps = sc;
      if (dn === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dv_a = '0; data_a = '0; dv_b = '0; data_b = '0;
    repeat (2) @(negedge clk);
    checks++; if (sclk_a !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", sclk_a); end
    checks++; if (cs_n_a !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n_a); end
    checks++; if (ldac_n_a !== 1'b1) begin errors++; $display("FAIL reset_ldac_n: got %b want 1", ldac_n_a); end
    checks++; if (dout_a !== 2'b00) begin errors++; $display("FAIL reset_dout: got %b want 00", dout_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
    checks++; if (cs_n_b !== 1'b1 || dout_b !== 4'h0) begin errors++; $display("FAIL reset_b: got cs_n=%b dout=%h want 1/0", cs_n_b, dout_b); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ldac_n_a !== EXP_LDAC_IDLE) begin errors++; $display("FAIL idle_ldac_n: got %b want %b", ldac_n_a, EXP_LDAC_IDLE); end
    checks++; if (busy_a !== 1'b0 || cs_n_a !== 1'b1) begin errors++; $display("FAIL idle_after_reset: got busy=%b cs_n=%b want 0/1", busy_a, cs_n_a); end
  endtask

  task automatic test_basic_frame();
    int cl, bh, ll, rs;
    logic [3:0][15:0] bt;
    logic fc;
    bit to;
    data_a = {12'h000, 12'hA5C}; dv_a = 2'b01;
    @(negedge clk);
    dv_a = 2'b00;
    checks++; if (cs_n_a !== 1'b1) begin errors++; $display("FAIL basic_cs_before: got %b want 1", cs_n_a); end
    capture(1'b0, cl, bh, ll, rs, bt, fc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", to); end
    checks++; if (fc !== 1'b0) begin errors++; $display("FAIL basic_first_cs: got %b want 0", fc); end
    checks++; if (cl !== 136) begin errors++; $display("FAIL basic_cs_low: got %0d want 136", cl); end
    checks++; if (bh !== EXP_BUSY_A) begin errors++; $display("FAIL basic_busy: got %0d want %0d", bh, EXP_BUSY_A); end
    checks++; if (ll !== EXP_LDAC_A) begin errors++; $display("FAIL basic_ldac_low: got %0d want %0d", ll, EXP_LDAC_A); end
    checks++; if (rs !== 16) begin errors++; $display("FAIL basic_sclk_rises: got %0d want 16", rs); end
    checks++; if (bt[0] !== 16'h0A5C) begin errors++; $display("FAIL basic_dout0: got %h want 0a5c", bt[0]); end
    checks++; if (bt[1] !== 16'h0000) begin errors++; $display("FAIL basic_dout1: got %h want 0000", bt[1]); end
    @(negedge clk);
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done_a); end
    checks++; if (busy_a !== 1'b0 || cs_n_a !== 1'b1 || sclk_a !== 1'b1) begin errors++; $display("FAIL basic_idle: got busy=%b cs_n=%b sclk=%b want 0/1/1", busy_a, cs_n_a, sclk_a); end
  endtask

  task automatic test_overwrite();
    int cl, bh, ll, rs, extra;
    logic [3:0][15:0] bt;
    logic fc;
    bit to;
    data_a = {12'h000, 12'h7E1}; dv_a = 2'b01;
    @(negedge clk);
    dv_a = 2'b00;
    fork
      capture(1'b0, cl, bh, ll, rs, bt, fc, to);
      begin
        repeat (10) @(negedge clk);
        data_a[23:12] = 12'h123; dv_a = 2'b10;
        @(negedge clk);
        dv_a = 2'b00;
        @(negedge clk);
        data_a[23:12] = 12'h456; dv_a = 2'b10;
        @(negedge clk);
        dv_a = 2'b00;
      end
    join
    checks++; if (to !== 1'b0 || bt[0] !== 16'h07E1 || bt[1] !== 16'h0000) begin errors++; $display("FAIL ovw_frame1: got to=%b d0=%h d1=%h want 0/07e1/0000", to, bt[0], bt[1]); end
    capture(1'b0, cl, bh, ll, rs, bt, fc, to);
    checks++; if (to !== 1'b0 || fc !== 1'b0 || cl !== 136) begin errors++; $display("FAIL ovw_frame2_timing: got to=%b first_cs=%b cs_low=%0d want 0/0/136", to, fc, cl); end
    checks++; if (bt[1] !== 16'h0456) begin errors++; $display("FAIL ovw_last_wins: got %h want 0456", bt[1]); end
    checks++; if (bt[0] !== 16'h07E1) begin errors++; $display("FAIL ovw_retransmit: got %h want 07e1", bt[0]); end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (cs_n_a !== 1'b1 || busy_a !== 1'b0) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ovw_single_frame: got %0d busy cycles want 0", extra); end
  endtask

  task automatic test_busy_write();
    int cl, bh, ll, rs;
    logic [3:0][15:0] bt;
    logic fc;
    bit to;
    data_a[11:0] = 12'h222; dv_a = 2'b01;
    @(negedge clk);
    dv_a = 2'b00;
    fork
      capture(1'b0, cl, bh, ll, rs, bt, fc, to);
      begin
        repeat (40) @(negedge clk);
        data_a[11:0] = 12'h111; dv_a = 2'b01;
        @(negedge clk);
        dv_a = 2'b00;
      end
    join
    checks++; if (to !== 1'b0 || bt[0] !== 16'h0222 || bt[1] !== 16'h0456) begin errors++; $display("FAIL busy_frame1: got to=%b d0=%h d1=%h want 0/0222/0456", to, bt[0], bt[1]); end
    capture(1'b0, cl, bh, ll, rs, bt, fc, to);
    checks++; if (to !== 1'b0 || fc !== 1'b0 || bt[0] !== 16'h0111 || bt[1] !== 16'h0456) begin errors++; $display("FAIL busy_frame2: got to=%b first_cs=%b d0=%h d1=%h want 0/0/0111/0456", to, fc, bt[0], bt[1]); end
    @(negedge clk);
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL busy_end: got done=%b busy=%b want 0/0", done_a, busy_a); end
  endtask

  task automatic test_snapshot_collision();
    int cl, bh, ll, rs;
    logic [3:0][15:0] bt;
    logic fc;
    bit to;
    data_a[11:0] = 12'hAAA; dv_a = 2'b01;
    @(negedge clk);
    data_a[11:0] = 12'h555;
    checks++; if (cs_n_a !== 1'b1) begin errors++; $display("FAIL snap_cs_before: got %b want 1", cs_n_a); end
    fork
      capture(1'b0, cl, bh, ll, rs, bt, fc, to);
      begin
        @(negedge clk);
        dv_a = 2'b00;
      end
    join
    checks++; if (to !== 1'b0 || bt[0] !== 16'h0AAA) begin errors++; $display("FAIL snap_frame1: got to=%b d0=%h want 0/0aaa", to, bt[0]); end
    capture(1'b0, cl, bh, ll, rs, bt, fc, to);
    checks++; if (to !== 1'b0 || fc !== 1'b0 || bt[0] !== 16'h0555 || bt[1] !== 16'h0456) begin errors++; $display("FAIL snap_frame2: got to=%b first_cs=%b d0=%h d1=%h want 0/0/0555/0456", to, fc, bt[0], bt[1]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int cl, bh, ll, rs, r, bad_sclk, bad_cs, bad_ldac;
    logic [3:0][15:0] bt;
    logic fc, ps;
    bit to;
    data_a[11:0] = 12'hF0F; dv_a = 2'b01;
    @(negedge clk);
    dv_a = 2'b00;
    r = 0; ps = 1'b1;
    for (int i = 0; i < 200 && r < 7; i++) begin
      @(negedge clk);
      if (!ps && sclk_a) r++;
      ps = sclk_a;
    end
    checks++; if (r !== 7 || busy_a !== 1'b1) begin errors++; $display("FAIL rstmid_reach_bit7: got rises=%0d busy=%b want 7/1", r, busy_a); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (cs_n_a !== 1'b1 || sclk_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got cs_n=%b sclk=%b busy=%b want 1/1/0", cs_n_a, sclk_a, busy_a); end
    checks++; if (ldac_n_a !== 1'b1 || dout_a !== 2'b00 || done_a !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got ldac_n=%b dout=%b done=%b want 1/00/0", ldac_n_a, dout_a, done_a); end
    rst_n = 1'b1;
    bad_sclk = 0; bad_cs = 0; bad_ldac = 0;
    repeat (30) begin
      @(negedge clk);
      if (sclk_a !== 1'b1) bad_sclk++;
      if (cs_n_a !== 1'b1 || busy_a !== 1'b0) bad_cs++;
      if (ldac_n_a !== EXP_LDAC_IDLE) bad_ldac++;
    end
    checks++; if (bad_sclk !== 0 || bad_cs !== 0) begin errors++; $display("FAIL rstmid_quiet: got sclk_low=%0d active=%0d want 0/0", bad_sclk, bad_cs); end
    checks++; if (bad_ldac !== 0) begin errors++; $display("FAIL rstmid_no_ldac: got %0d wrong cycles want 0", bad_ldac); end
    data_a[23:12] = 12'h321; dv_a = 2'b10;
    @(negedge clk);
    dv_a = 2'b00;
    capture(1'b0, cl, bh, ll, rs, bt, fc, to);
    checks++; if (to !== 1'b0 || cl !== 136 || ll !== EXP_LDAC_A) begin errors++; $display("FAIL rstmid_clean_timing: got to=%b cs_low=%0d ldac_low=%0d want 0/136/%0d", to, cl, ll, EXP_LDAC_A); end
    checks++; if (bt[0] !== 16'h0000 || bt[1] !== 16'h0321) begin errors++; $display("FAIL rstmid_clean_data: got d0=%h d1=%h want 0000/0321", bt[0], bt[1]); end
    @(negedge clk);
  endtask

  task automatic test_four_channels();
    int cl, bh, ll, rs;
    logic [3:0][15:0] bt;
    logic fc;
    bit to;
    data_b = {12'hABC, 12'h789, 12'h456, 12'h123}; dv_b = 4'hF;
    @(negedge clk);
    dv_b = 4'h0;
    checks++; if (cs_n_b !== 1'b1) begin errors++; $display("FAIL nch4_cs_before: got %b want 1", cs_n_b); end
    capture(1'b1, cl, bh, ll, rs, bt, fc, to);
    checks++; if (to !== 1'b0 || fc !== 1'b0 || cl !== 68) begin errors++; $display("FAIL nch4_cs_low: got to=%b first_cs=%b cs_low=%0d want 0/0/68", to, fc, cl); end
    checks++; if (bh !== EXP_BUSY_B || ll !== EXP_LDAC_B || rs !== 16) begin errors++; $display("FAIL nch4_timing: got busy=%0d ldac_low=%0d rises=%0d want %0d/%0d/16", bh, ll, rs, EXP_BUSY_B, EXP_LDAC_B); end
    checks++; if (bt !== {16'h0ABC, 16'h0789, 16'h0456, 16'h0123}) begin errors++; $display("FAIL nch4_data: got %h want 0abc078904560123", bt); end
    data_b[35:24] = 12'hFED; dv_b = 4'b0100;
    @(negedge clk);
    dv_b = 4'h0;
    capture(1'b1, cl, bh, ll, rs, bt, fc, to);
    checks++; if (to !== 1'b0 || cl !== 68) begin errors++; $display("FAIL nch4_frame2_timing: got to=%b cs_low=%0d want 0/68", to, cl); end
    checks++; if (bt !== {16'h0ABC, 16'h0FED, 16'h0456, 16'h0123}) begin errors++; $display("FAIL nch4_frame2_data: got %h want 0abc0fed04560123", bt); end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_overwrite();
    test_busy_write();
    test_snapshot_collision();
    test_reset_mid_frame();
    test_four_channels();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
